// File: rtl/prime_test_if.sv
// rtl/prime_test_if.sv - request/response bus between prime_test and its modulo unit
interface prime_test_if #(
    parameter int WIDTH = 16
);
    logic             mod_go;
    logic [WIDTH-1:0] mod_a;
    logic [WIDTH-1:0] mod_b;
    logic             mod_ready;
    logic             mod_error;
    logic [WIDTH-1:0] mod_res;

    modport master (
        output mod_go,
        output mod_a,
        output mod_b,
        input  mod_ready,
        input  mod_error,
        input  mod_res
    );

    modport slave (
        input  mod_go,
        input  mod_a,
        input  mod_b,
        output mod_ready,
        output mod_error,
        output mod_res
    );
endinterface

// File: rtl/prime_test.sv
// rtl/prime_test.sv - trial-division primality tester driving a modulo unit
module prime_test #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             is_prime,
    output logic             error,
    prime_test_if.master     mbus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   n_r, n_r_nx;
    logic [WIDTH-1:0]   d, d_nx;
    logic               is_prime_nx;
    logic               error_nx;
    logic               first_wait, first_wait_nx;
    logic [2*WIDTH-1:0] d_sq;

    // Square at double width so the loop bound cannot overflow near 2^WIDTH.
    assign d_sq = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            n_r        <= '0;
            d          <= '0;
            is_prime   <= 1'b0;
            error      <= 1'b0;
            first_wait <= 1'b0;
        end else begin
            state      <= state_nx;
            n_r        <= n_r_nx;
            d          <= d_nx;
            is_prime   <= is_prime_nx;
            error      <= error_nx;
            first_wait <= first_wait_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        n_r_nx        = n_r;
        d_nx          = d;
        is_prime_nx   = is_prime;
        error_nx      = error;
        first_wait_nx = first_wait;
        case (state)
            S_IDLE: begin
                if (go) begin
                    n_r_nx      = n;
                    d_nx        = WIDTH'(2);
                    error_nx    = 1'b0;
                    is_prime_nx = 1'b0;
                    state_nx    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (n_r < WIDTH'(2)) begin
                    is_prime_nx = 1'b0;
                    state_nx    = S_DONE;
                end else if (d_sq > {{WIDTH{1'b0}}, n_r}) begin
                    is_prime_nx = 1'b1;
                    state_nx    = S_DONE;
                end else begin
                    state_nx    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                first_wait_nx = 1'b1;
                state_nx      = S_WAIT;
            end
            S_WAIT: begin
                // mod_ready in the first WAIT cycle may still be the previous completion.
                if (first_wait) begin
                    first_wait_nx = 1'b0;
                end else if (mbus.mod_ready) begin
                    if (mbus.mod_error) begin
                        error_nx    = 1'b1;
                        is_prime_nx = 1'b0;
                        state_nx    = S_DONE;
                    end else if (mbus.mod_res == '0) begin
                        is_prime_nx = 1'b0;
                        state_nx    = S_DONE;
                    end else begin
                        d_nx     = (d == WIDTH'(2)) ? WIDTH'(3) : d + WIDTH'(2);
                        state_nx = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign ready       = (state == S_IDLE);
    assign mbus.mod_go = (state == S_ISSUE);
    assign mbus.mod_a  = n_r;
    assign mbus.mod_b  = d;

endmodule

// File: tb/tb_prime_test.sv
// tb/tb_prime_test.sv - randomized self-checking bench for prime_test with a behavioural modulo unit
module tb_prime_test;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go  = 1'b0;
    logic [W-1:0] n   = '0;
    logic         ready;
    logic         is_prime;
    logic         error;

    prime_test_if #(.WIDTH(W)) mbus ();

    prime_test #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .n        (n),
        .ready    (ready),
        .is_prime (is_prime),
        .error    (error),
        .mbus     (mbus.master)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural modulo unit: ready drops on a request, returns after mod_lat cycles.
    int           mod_lat  = 2;
    bit           err_next = 1'b0;
    logic [W-1:0] cur_n    = '0;
    int           pulse_cnt  = 0;
    int           proto_viol = 0;
    logic [W-1:0] div_q[$];
    logic         m_busy;
    int           m_cnt;
    logic         prev_go;
    logic [W-1:0] m_a, m_b;
    logic         m_err_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy         <= 1'b0;
            m_cnt          <= 0;
            prev_go        <= 1'b0;
            m_a            <= '0;
            m_b            <= '0;
            m_err_pend     <= 1'b0;
            mbus.mod_ready <= 1'b1;
            mbus.mod_error <= 1'b0;
            mbus.mod_res   <= '0;
        end else begin
            prev_go <= mbus.mod_go;
            if (mbus.mod_go) begin
                pulse_cnt++;
                div_q.push_back(mbus.mod_b);
                if (prev_go || m_busy || mbus.mod_a !== cur_n) proto_viol++;
                m_busy         <= 1'b1;
                m_cnt          <= mod_lat;
                m_a            <= mbus.mod_a;
                m_b            <= mbus.mod_b;
                m_err_pend     <= err_next;
                mbus.mod_ready <= 1'b0;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy         <= 1'b0;
                    mbus.mod_ready <= 1'b1;
                    mbus.mod_error <= m_err_pend;
                    mbus.mod_res   <= m_err_pend ? '0 : m_a % m_b;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: trial divisors 2,3,5,7,... while d*d<=n, stopping at the first exact divisor.
    int exp_q[$];
    task automatic ref_divs(input int nv);
        int dv;
        exp_q.delete();
        dv = 2;
        while (dv * dv <= nv) begin
            exp_q.push_back(dv);
            if (nv % dv == 0) break;
            dv = (dv == 2) ? 3 : dv + 2;
        end
    endtask

    function automatic bit ref_prime(input int nv);
        if (nv < 2) return 1'b0;
        for (int k = 2; k * k <= nv; k++)
            if (nv % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    int base;

    // Runs one test; optionally pokes a go with n=4 while busy. Returns the cycle ready came back.
    task automatic run_one(input logic [W-1:0] nv, input bit poke, output int cyc);
        @(negedge clk);
        mod_lat = $urandom_range(1, 4);
        cur_n   = nv;
        base    = pulse_cnt;
        go      = 1'b1;
        n       = nv;
        @(negedge clk);
        go  = 1'b0;
        n   = W'($urandom);
        check("ready_drop", {31'd0, ready}, 32'd1 - 32'd1);
        cyc = 1;
        while (!ready && cyc < 6000) begin
            if (poke && cyc == 4) begin
                go = 1'b1;
                n  = 4;
            end else begin
                go = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        if (!ready) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic verify(input string tag, input int nv, input bit exp_p, input bit exp_err);
        int np;
        ref_divs(nv);
        np = pulse_cnt - base;
        check({tag, "_prime"}, {31'd0, is_prime}, {31'd0, exp_p});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_pulses"}, np, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < np; i++)
            check({tag, "_divisor"}, {16'd0, div_q[base + i]}, exp_q[i]);
    endtask

    bit sieve[0:200];

    initial begin
        int cyc;
        int rn;

        for (int i = 0; i <= 200; i++) sieve[i] = (i >= 2);
        for (int i = 2; i * i <= 200; i++)
            if (sieve[i])
                for (int j = i * i; j <= 200; j += i) sieve[j] = 1'b0;

        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_is_prime", {31'd0, is_prime}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_mod_go", {31'd0, mbus.mod_go}, 32'd0);
        check("rst_mod_a", {16'd0, mbus.mod_a}, 32'd0);
        check("rst_mod_b", {16'd0, mbus.mod_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_one(W'(v), 1'b0, cyc);
            check("small_latency", cyc, 3);
            verify("small", v, (v >= 2), 1'b0);
        end

        run_one(4, 1'b0, cyc);     verify("n4", 4, 1'b0, 1'b0);
        run_one(9, 1'b0, cyc);     verify("n9", 9, 1'b0, 1'b0);
        run_one(25, 1'b0, cyc);    verify("n25", 25, 1'b0, 1'b0);
        check("n25_count", pulse_cnt - base, 3);
        run_one(97, 1'b0, cyc);    verify("n97", 97, 1'b1, 1'b0);
        check("n97_count", pulse_cnt - base, 5);
        run_one(65521, 1'b0, cyc); verify("n65521", 65521, 1'b1, 1'b0);

        for (int v = 0; v <= 200; v++) begin
            run_one(W'(v), 1'b0, cyc);
            check("sweep_prime", {31'd0, is_prime}, {31'd0, sieve[v]});
            ref_divs(v);
            check("sweep_pulses", pulse_cnt - base, exp_q.size());
        end

        for (int k = 0; k < 20; k++) begin
            rn = $urandom_range(0, 65535);
            run_one(W'(rn), 1'b0, cyc);
            verify("rand", rn, ref_prime(rn), 1'b0);
        end

        run_one(97, 1'b1, cyc);    verify("poke97", 97, 1'b1, 1'b0);
        run_one(4, 1'b0, cyc);     verify("after_poke", 4, 1'b0, 1'b0);

        err_next = 1'b1;
        run_one(15, 1'b0, cyc);
        err_next = 1'b0;
        check("err_flag", {31'd0, error}, 32'd1);
        check("err_prime", {31'd0, is_prime}, 32'd0);
        check("err_ready", {31'd0, ready}, 32'd1);
        check("err_pulses", pulse_cnt - base, 1);
        run_one(7, 1'b0, cyc);     verify("err_clear", 7, 1'b1, 1'b0);

        @(negedge clk);
        mod_lat = 4;
        cur_n   = 65521;
        go      = 1'b1;
        n       = 65521;
        @(negedge clk);
        go  = 1'b0;
        base = pulse_cnt;
        cyc = 0;
        while (pulse_cnt - base < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_wait", (pulse_cnt - base >= 3) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        check("rst_busy_before", {31'd0, ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_is_prime", {31'd0, is_prime}, 32'd0);
        check("midrst_mod_go", {31'd0, mbus.mod_go}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = pulse_cnt;
        repeat (20) @(negedge clk);
        check("midrst_no_pulses", pulse_cnt - base, 0);
        check("midrst_idle", {31'd0, ready}, 32'd1);
        run_one(13, 1'b0, cyc);    verify("post_rst13", 13, 1'b1, 1'b0);

        check("protocol", proto_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
